// File: rtl/peripheral_dsa_pkg.sv
// Shared constants and FSM state encoding for the DSA modular exponentiator slice.
//   DATA_SIZE   : default operand/result width
//   dsa_state_e : exponentiator controller states
package peripheral_dsa_pkg;

    localparam int unsigned DATA_SIZE = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        MUL   = 3'd2,
        SQR   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } dsa_state_e;

endpackage

// File: rtl/peripheral_dsa_modular_multiplier.sv
// Serial modular multiplier: DATA_OUT = DATA_A_IN * DATA_B_IN mod MODULO.
// Interleaved MSB-first shift-add, one bit of DATA_B_IN per cycle.
// Ports:
//   CLK, RST   : clock, synchronous active-high reset
//   START      : 1-cycle request, operands sampled on the same edge (ignored while busy)
//   MODULO     : modulus M
//   DATA_A_IN  : addend operand x, must satisfy x < M
//   DATA_B_IN  : multiplier operand y, scanned MSB first
//   READY      : 1-cycle pulse, DATA_SIZE+1 cycles after START
//   DATA_OUT   : product, updated with READY
module peripheral_dsa_modular_multiplier #(
    parameter int unsigned DATA_SIZE = peripheral_dsa_pkg::DATA_SIZE
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [DATA_SIZE-1:0] MODULO,
    input  logic [DATA_SIZE-1:0] DATA_A_IN,
    input  logic [DATA_SIZE-1:0] DATA_B_IN,
    output logic                 READY,
    output logic [DATA_SIZE-1:0] DATA_OUT
);

    localparam int unsigned AW    = DATA_SIZE + 1;
    localparam int unsigned CNT_W = $clog2(DATA_SIZE + 1);

    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_SIZE-1:0] acc_q, acc_d;
    logic [DATA_SIZE-1:0] x_q, x_d;
    logic [DATA_SIZE-1:0] y_q, y_d;
    logic [DATA_SIZE-1:0] m_q, m_d;
    logic                 ready_q, ready_d;
    logic [DATA_SIZE-1:0] data_out_q, data_out_d;

    logic [AW-1:0]        m_ext, acc_dbl, acc_r1, acc_add;
    logic [DATA_SIZE-1:0] acc_r2;

    // One reduction step; acc stays below M, so AW bits never overflow
    always_comb begin
        m_ext   = {1'b0, m_q};
        acc_dbl = {acc_q, 1'b0};
        acc_r1  = (acc_dbl >= m_ext) ? (acc_dbl - m_ext) : acc_dbl;
        acc_add = y_q[DATA_SIZE-1] ? (acc_r1 + {1'b0, x_q}) : acc_r1;
        acc_r2  = (acc_add >= m_ext) ? DATA_SIZE'(acc_add - m_ext) : DATA_SIZE'(acc_add);
    end

    // Next-state: load on START, then DATA_SIZE iteration cycles
    always_comb begin
        busy_d     = busy_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        x_d        = x_q;
        y_d        = y_q;
        m_d        = m_q;
        ready_d    = 1'b0;
        data_out_d = data_out_q;
        if (!busy_q) begin
            if (START) begin
                busy_d = 1'b1;
                cnt_d  = CNT_W'(DATA_SIZE);
                acc_d  = '0;
                x_d    = DATA_A_IN;
                y_d    = DATA_B_IN;
                m_d    = MODULO;
            end
        end else begin
            acc_d = acc_r2;
            y_d   = {y_q[DATA_SIZE-2:0], 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d     = 1'b0;
                ready_d    = 1'b1;
                data_out_d = acc_r2;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            m_q        <= '0;
            ready_q    <= 1'b0;
            data_out_q <= '0;
        end else begin
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            x_q        <= x_d;
            y_q        <= y_d;
            m_q        <= m_d;
            ready_q    <= ready_d;
            data_out_q <= data_out_d;
        end
    end

    assign READY    = ready_q;
    assign DATA_OUT = data_out_q;

endmodule

// File: rtl/peripheral_dsa_modular_exponentiator.sv
// Modular exponentiation DATA_OUT = BASE_IN ^ EXPONENT_IN mod MODULO,
// right-to-left square-and-multiply over all DATA_SIZE exponent bits
// using a single shared serial modular multiplier.
// Ports:
//   CLK, RST     : clock, synchronous active-high reset (aborts a running op)
//   START        : 1-cycle request, accepted only in IDLE; operands latched then
//   MODULO       : modulus M
//   BASE_IN      : base B, B < M
//   EXPONENT_IN  : exponent E, unsigned
//   READY        : 1-cycle completion pulse
//   DATA_OUT     : result, valid from READY until the next result
module peripheral_dsa_modular_exponentiator #(
    parameter int unsigned DATA_SIZE = peripheral_dsa_pkg::DATA_SIZE
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [DATA_SIZE-1:0] MODULO,
    input  logic [DATA_SIZE-1:0] BASE_IN,
    input  logic [DATA_SIZE-1:0] EXPONENT_IN,
    output logic                 READY,
    output logic [DATA_SIZE-1:0] DATA_OUT
);

    import peripheral_dsa_pkg::*;

    localparam int unsigned CNT_W = $clog2(DATA_SIZE);

    dsa_state_e           state_q, state_d;
    logic [DATA_SIZE-1:0] m_q, m_d;
    logic [DATA_SIZE-1:0] b_q, b_d;
    logic [DATA_SIZE-1:0] e_q, e_d;
    logic [DATA_SIZE-1:0] res_q, res_d;
    logic [CNT_W-1:0]     bcnt_q, bcnt_d;
    logic                 issued_q, issued_d;
    logic                 ready_q, ready_d;
    logic [DATA_SIZE-1:0] data_out_q, data_out_d;

    logic                 mul_start_c;
    logic [DATA_SIZE-1:0] mul_a_c, mul_b_c;
    logic                 mul_ready;
    logic [DATA_SIZE-1:0] mul_out;

    // Controller: each MUL/SQR is issue, wait for multiplier, capture
    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        b_d         = b_q;
        e_d         = e_q;
        res_d       = res_q;
        bcnt_d      = bcnt_q;
        issued_d    = issued_q;
        mul_start_c = 1'b0;
        mul_a_c     = (state_q == MUL) ? res_q : b_q;
        mul_b_c     = b_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    m_d     = MODULO;
                    b_d     = BASE_IN;
                    e_d     = EXPONENT_IN;
                    state_d = INIT;
                end
            end
            INIT: begin
                // M of 0 or 1 forces a zero result through every product
                res_d   = (m_q <= DATA_SIZE'(1)) ? DATA_SIZE'(0) : DATA_SIZE'(1);
                bcnt_d  = '0;
                state_d = e_q[0] ? MUL : SQR;
            end
            MUL, SQR: begin
                if (!issued_q) begin
                    mul_start_c = 1'b1;
                    issued_d    = 1'b1;
                end else if (mul_ready) begin
                    issued_d = 1'b0;
                    if (state_q == MUL) begin
                        res_d   = mul_out;
                        state_d = SQR;
                    end else begin
                        b_d     = mul_out;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                e_d    = e_q >> 1;
                bcnt_d = bcnt_q + CNT_W'(1);
                if (bcnt_q == CNT_W'(DATA_SIZE - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = e_q[1] ? MUL : SQR;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // READY and DATA_OUT become visible together with the DONE state
        ready_d    = (state_d == DONE);
        data_out_d = (state_d == DONE) ? res_q : data_out_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            m_q        <= '0;
            b_q        <= '0;
            e_q        <= '0;
            res_q      <= '0;
            bcnt_q     <= '0;
            issued_q   <= 1'b0;
            ready_q    <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            b_q        <= b_d;
            e_q        <= e_d;
            res_q      <= res_d;
            bcnt_q     <= bcnt_d;
            issued_q   <= issued_d;
            ready_q    <= ready_d;
            data_out_q <= data_out_d;
        end
    end

    peripheral_dsa_modular_multiplier #(
        .DATA_SIZE (DATA_SIZE)
    ) u_mul (
        .CLK       (CLK),
        .RST       (RST),
        .START     (mul_start_c),
        .MODULO    (m_q),
        .DATA_A_IN (mul_a_c),
        .DATA_B_IN (mul_b_c),
        .READY     (mul_ready),
        .DATA_OUT  (mul_out)
    );

    assign READY    = ready_q;
    assign DATA_OUT = data_out_q;

endmodule

// File: tb/tb_peripheral_dsa_modular_exponentiator.sv
// Self-checking bench: directed table at DATA_SIZE=16, two vectors at DATA_SIZE=8,
// START re-pulsing, mid-operation reset and a reference-model sweep.
module tb_peripheral_dsa_modular_exponentiator;

    import peripheral_dsa_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start16, start8;
    logic [15:0] mod16, base16, exp16, dout16;
    logic [7:0]  mod8, base8, exp8, dout8;
    logic        ready16, ready8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    peripheral_dsa_modular_exponentiator #(.DATA_SIZE(16)) dut16 (
        .CLK(clk), .RST(rst), .START(start16), .MODULO(mod16), .BASE_IN(base16),
        .EXPONENT_IN(exp16), .READY(ready16), .DATA_OUT(dout16)
    );

    peripheral_dsa_modular_exponentiator #(.DATA_SIZE(8)) dut8 (
        .CLK(clk), .RST(rst), .START(start8), .MODULO(mod8), .BASE_IN(base8),
        .EXPONENT_IN(exp8), .READY(ready8), .DATA_OUT(dout8)
    );

    typedef struct {
        logic [15:0] m;
        logic [15:0] b;
        logic [15:0] e;
        logic [15:0] res;
        int          lat;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint unsigned powmod16(input longint unsigned m, input longint unsigned b,
                                                 input longint unsigned e);
        longint unsigned r, bb;
        if (m == 0) return 0;
        r  = 1 % m;
        bb = b % m;
        for (int i = 0; i < 16; i++) begin
            if (((e >> i) & 1) != 0) r = (r * bb) % m;
            bb = (bb * bb) % m;
        end
        return r;
    endfunction

    function automatic int lat16(input logic [15:0] e);
        return 2 + (16 + $countones(e)) * 18 + 16;
    endfunction

    // Runs one op; lat counts edges from the START-sampling edge to the READY cycle.
    // With repulse set, START is re-asserted every 10 cycles and held through DONE.
    task automatic op16(input logic [15:0] m, input logic [15:0] b, input logic [15:0] e,
                        input bit repulse, output logic [15:0] res, output int lat);
        @(posedge clk); #1;
        start16 = 1'b1; mod16 = m; base16 = b; exp16 = e;
        @(posedge clk); #1;
        start16 = 1'b0;
        mod16 = 16'($urandom); base16 = 16'($urandom); exp16 = 16'($urandom);
        lat = 1;
        while (!ready16 && lat < 3000) begin
            start16 = repulse && (lat % 10 == 0);
            @(posedge clk); #1;
            lat++;
        end
        start16 = repulse;
        res = dout16;
        check("op16_ready_seen", 64'(ready16), 1);
        @(posedge clk); #1;
        start16 = 1'b0;
        check("op16_ready_one_cycle", 64'(ready16), 0);
    endtask

    task automatic op8(input logic [7:0] m, input logic [7:0] b, input logic [7:0] e,
                       output logic [7:0] res, output int lat);
        @(posedge clk); #1;
        start8 = 1'b1; mod8 = m; base8 = b; exp8 = e;
        @(posedge clk); #1;
        start8 = 1'b0; mod8 = 8'($urandom); base8 = 8'($urandom); exp8 = 8'($urandom);
        lat = 1;
        while (!ready8 && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
        end
        res = dout8;
        @(posedge clk); #1;
        check("op8_ready_one_cycle", 64'(ready8), 0);
    endtask

    initial begin
        logic [15:0] r16, m, b, e;
        logic [7:0]  r8;
        int          lat, nready;

        vecs[0]  = '{16'd497,   16'd4,     16'd13,    16'd445,   360};
        vecs[1]  = '{16'd1000,  16'd2,     16'd10,    16'd24,    342};
        vecs[2]  = '{16'd13,    16'd5,     16'd0,     16'd1,     306};
        vecs[3]  = '{16'd1,     16'd0,     16'd9,     16'd0,     342};
        vecs[4]  = '{16'd0,     16'd0,     16'd5,     16'd0,     342};
        vecs[5]  = '{16'd11,    16'd2,     16'd10,    16'd1,     342};
        vecs[6]  = '{16'd2,     16'd1,     16'hFFFF,  16'd1,     594};
        vecs[7]  = '{16'd65535, 16'd0,     16'd7,     16'd0,     360};
        vecs[8]  = '{16'd100,   16'd99,    16'd2,     16'd1,     324};
        vecs[9]  = '{16'd65535, 16'd65534, 16'd3,     16'd65534, 342};
        vecs[10] = '{16'd17,    16'd3,     16'd16,    16'd1,     324};

        rst = 1'b1; start16 = 1'b0; start8 = 1'b0;
        mod16 = '0; base16 = '0; exp16 = '0; mod8 = '0; base8 = '0; exp8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready16", 64'(ready16), 0);
        check("reset_dout16", 64'(dout16), 0);
        check("reset_state16", 64'(dut16.state_q), 64'(IDLE));
        check("reset_ready8", 64'(ready8), 0);
        check("reset_dout8", 64'(dout8), 0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            op16(vecs[i].m, vecs[i].b, vecs[i].e, 1'b0, r16, lat);
            check($sformatf("vec%0d_result", i), 64'(r16), 64'(vecs[i].res));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
        end

        op8(8'd7, 8'd3, 8'd5, r8, lat);
        check("ds8_a_result", 64'(r8), 5);
        check("ds8_a_latency", 64'(lat), 110);
        op8(8'd13, 8'd2, 8'd255, r8, lat);
        check("ds8_b_result", 64'(r8), 8);
        check("ds8_b_latency", 64'(lat), 170);

        // START re-pulsed during the op and held across DONE: must be ignored
        op16(16'd497, 16'd4, 16'd13, 1'b1, r16, lat);
        check("repulse_result", 64'(r16), 445);
        check("repulse_latency", 64'(lat), 360);
        nready = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (ready16) nready++;
        end
        check("repulse_no_extra_ready", 64'(nready), 0);
        check("repulse_state_idle", 64'(dut16.state_q), 64'(IDLE));
        check("repulse_dout_held", 64'(dout16), 445);
        op16(16'd1000, 16'd2, 16'd10, 1'b0, r16, lat);
        check("after_repulse_result", 64'(r16), 24);

        // Reset at cycle 100 of an op aborts it
        @(posedge clk); #1;
        start16 = 1'b1; mod16 = 16'd497; base16 = 16'd4; exp16 = 16'd13;
        @(posedge clk); #1;
        start16 = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_ready", 64'(ready16), 0);
        check("abort_dout", 64'(dout16), 0);
        check("abort_state_idle", 64'(dut16.state_q), 64'(IDLE));
        nready = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (ready16) nready++;
        end
        check("abort_no_ready", 64'(nready), 0);
        op16(16'd11, 16'd2, 16'd10, 1'b0, r16, lat);
        check("after_abort_result", 64'(r16), 1);
        check("after_abort_latency", 64'(lat), 342);

        // Sweep against the reference model
        for (int k = 0; k < 60; k++) begin
            m = 16'($urandom_range(65535, 2));
            b = 16'($urandom_range(32'(m) - 1, 0));
            e = 16'($urandom);
            op16(m, b, e, 1'b0, r16, lat);
            check($sformatf("sweep%0d_result m=%0d b=%0d e=%0d", k, m, b, e),
                  64'(r16), 64'(powmod16(64'(m), 64'(b), 64'(e))));
            check($sformatf("sweep%0d_latency", k), 64'(lat), 64'(lat16(e)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
